nvram_upload_reader: RTL and testbench
======================================

Name: nvram_upload_reader

Overview:
- Read-side counterpart of the ioctl download path: serves bytes back to hps_io when the HPS uploads (saves) a memory image, such as high-score NVRAM.
- Decodes upload read strobes for one ioctl index.
- Fetches each byte from the board NVRAM through a req/ack port, presents it on ioctl_din and holds ioctl_wait until the byte is valid.
- Sits between hps_io and mylstar_board in clk_sys domain.

Parameters:
- ADDR_W, 10, NVRAM address width; image size is 2**ADDR_W bytes.
- UPLOAD_INDEX, 4, ioctl_index value this block responds to.
- TIMEOUT, 63, max clk_sys cycles to wait for nv_ack before substituting fill byte.
- OOR_BYTE, 8'hFF, byte returned for addresses at or above 2**ADDR_W.
- TMO_BYTE, 8'hEE, byte returned on ack timeout.

Ports:
- clk_sys  in  1  system clock; all logic is in this domain.
- reset  in  1  asynchronous, active-high reset.
- ioctl_upload  in  1  HPS upload session active.
- ioctl_index  in  8  selected image index.
- ioctl_addr  in  25  byte address of the requested read.
- ioctl_rd  in  1  one-cycle read strobe from hps_io.
- ioctl_din  out  8  byte returned to hps_io.
- ioctl_wait  out  1  stalls the HPS while a fetch is outstanding.
- nv_req  out  1  NVRAM read request, level, held until ack.
- nv_addr  out  ADDR_W  NVRAM read address.
- nv_data  in  8  NVRAM read data, valid when nv_ack=1.
- nv_ack  in  1  one-cycle acknowledge from the NVRAM arbiter.
- nv_hold  out  1  freezes game-side NVRAM writes during a matching upload.
- done  out  1  one-cycle pulse when a matching upload session ends.
- timeout_err  out  1  sticky flag set on any ack timeout; cleared at the start of the next matching session.

Behaviour:
- Reset values: ioctl_din=0, ioctl_wait=0, nv_req=0, nv_addr=0, nv_hold=0, done=0, timeout_err=0, FSM=IDLE, timeout counter=0.
- sel = ioctl_upload & (ioctl_index==UPLOAD_INDEX). nv_hold is a register that follows sel with 1 cycle of latency.
- The FSM has four states: IDLE, REQ, PRESENT, ABORT.
- IDLE, on ioctl_rd & sel:
  - If ioctl_addr[24:ADDR_W] != 0: load ioctl_din=OOR_BYTE, go to PRESENT, no request issued.
  - Otherwise: latch nv_addr=ioctl_addr[ADDR_W-1:0], set nv_req=1 and ioctl_wait=1, clear the counter, go to REQ. Both outputs are registered, so they are visible the cycle after the strobe.
- ioctl_rd while not in IDLE, or with sel=0, is ignored.
- REQ:
  - On nv_ack: ioctl_din=nv_data, nv_req=0, ioctl_wait=0, go to PRESENT.
  - Otherwise the counter increments. When it reaches TIMEOUT: ioctl_din=TMO_BYTE, nv_req=0, ioctl_wait=0, timeout_err=1, go to PRESENT.
  - If nv_ack arrives in the same cycle the counter reaches TIMEOUT, the ack wins.
- Latency: ack in cycle N after request means ioctl_din is valid and ioctl_wait is low in cycle N+1. A zero-wait arbiter gives 2 cycles from strobe to valid data.
- PRESENT: ioctl_din holds its value until the next accepted strobe. The FSM returns to IDLE next cycle, so back-to-back strobes are accepted every 3 cycles minimum.
- Session end: sel falling from 1 to 0 pulses done for one cycle.
  - If this happens in REQ: nv_req drops immediately, ioctl_wait drops, go to ABORT.
  - ABORT waits for nv_ack or TIMEOUT cycles, discards the data, then goes to IDLE. ioctl_din is unchanged.
- Session start: sel rising from 0 to 1 clears timeout_err.
- nv_addr changes only on an accepted strobe.
- Reset asserted mid-fetch forces all reset values asynchronously; a late nv_ack after reset release is ignored in IDLE.

Test Plan:
- Index 4, upload=1, rd at addr 0x005, arbiter acks 3 cycles after nv_req with 0x5A -> nv_addr=0x005, wait high 3 cycles, ioctl_din=0x5A the cycle after ack, wait low.
- Sequential reads 0x000..0x3FF, zero-wait arbiter returning addr[7:0] -> 1024 bytes match, no timeout_err, done pulses once when upload drops.
- rd at addr 0x400 -> ioctl_din=0xFF, nv_req never asserted, wait never asserted.
- Arbiter never acks -> wait drops after 63 cycles, ioctl_din=0xEE, timeout_err=1. A new session clears it. Also ack coincident with the 63rd cycle -> ack data returned, no error.
- ioctl_index=1 with rd strobes -> no nv_req, nv_hold=0, done never pulses.
- upload drops in REQ, then a late ack with 0x77 -> ioctl_wait/nv_req drop immediately, ioctl_din unchanged, FSM back in IDLE after the ack. Repeat with reset pulsed mid-REQ -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/nvram_upload_reader.sv
// nvram_upload_reader
//   Read side of the ioctl image path. When the HPS uploads (saves) the image
//   selected by UPLOAD_INDEX, each ioctl_rd strobe is turned into a single
//   NVRAM fetch over a level req / one-cycle ack port. The fetched byte is
//   presented on ioctl_din, and ioctl_wait stalls the HPS until that byte is
//   valid.
//
// Ports
//   clk_sys      system clock; all logic runs in this domain
//   reset        asynchronous, active-high reset
//   ioctl_upload HPS upload session active
//   ioctl_index  selected image index
//   ioctl_addr   byte address of the requested read
//   ioctl_rd     one-cycle read strobe
//   ioctl_din    byte returned to hps_io
//   ioctl_wait   high while a fetch is outstanding
//   nv_req       NVRAM read request, held until nv_ack
//   nv_addr      NVRAM read address
//   nv_data      NVRAM read data, valid with nv_ack
//   nv_ack       one-cycle acknowledge from the NVRAM arbiter
//   nv_hold      freezes game-side NVRAM writes during a matching upload
//   done         one-cycle pulse when a matching upload session ends
//   timeout_err  sticky ack-timeout flag, cleared when the next session starts
module nvram_upload_reader #(
   parameter int          ADDR_W       = 10,
   parameter logic [7:0]  UPLOAD_INDEX = 8'd4,
   parameter int          TIMEOUT      = 63,
   parameter logic [7:0]  OOR_BYTE     = 8'hFF,
   parameter logic [7:0]  TMO_BYTE     = 8'hEE
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_upload,
   input  logic [7:0]        ioctl_index,
   input  logic [24:0]       ioctl_addr,
   input  logic              ioctl_rd,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_wait,
   output logic              nv_req,
   output logic [ADDR_W-1:0] nv_addr,
   input  logic [7:0]        nv_data,
   input  logic              nv_ack,
   output logic              nv_hold,
   output logic              done,
   output logic              timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   // The counter starts at 0 in the first waiting cycle, so reaching
   // TIMEOUT waited cycles means the counter currently reads TIMEOUT-1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, PRESENT, ABORT} state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic sel;
   logic addr_oor;
   logic session_fall;
   logic session_rise;

   // nv_hold is sel delayed by one cycle, so it doubles as the edge detector.
   assign sel          = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
   assign addr_oor     = (ioctl_addr[24:ADDR_W] != '0);
   assign session_fall = nv_hold && !sel;
   assign session_rise = !nv_hold && sel;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         ioctl_din   <= 8'h00;
         ioctl_wait  <= 1'b0;
         nv_req      <= 1'b0;
         nv_addr     <= '0;
         nv_hold     <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         nv_hold <= sel;
         done    <= session_fall;
         if (session_rise)
            timeout_err <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (ioctl_rd && sel) begin
                  if (addr_oor) begin
                     ioctl_din <= OOR_BYTE;
                     state_reg <= PRESENT;
                  end else begin
                     nv_addr    <= ioctl_addr[ADDR_W-1:0];
                     nv_req     <= 1'b1;
                     ioctl_wait <= 1'b1;
                     cnt_reg    <= '0;
                     state_reg  <= REQ;
                  end
               end
            end

            REQ: begin
               if (session_fall) begin
                  // Drop the handshake at once. A coincident ack has already
                  // completed the fetch, so there is nothing left to drain.
                  nv_req     <= 1'b0;
                  ioctl_wait <= 1'b0;
                  cnt_reg    <= '0;
                  state_reg  <= nv_ack ? IDLE : ABORT;
               end else if (nv_ack) begin
                  // The ack is tested before the timeout, so it wins a tie.
                  ioctl_din  <= nv_data;
                  nv_req     <= 1'b0;
                  ioctl_wait <= 1'b0;
                  state_reg  <= PRESENT;
               end else if (cnt_reg == CNT_LAST) begin
                  ioctl_din   <= TMO_BYTE;
                  nv_req      <= 1'b0;
                  ioctl_wait  <= 1'b0;
                  timeout_err <= 1'b1;
                  state_reg   <= PRESENT;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end

            PRESENT: state_reg <= IDLE;

            ABORT: begin
               // Drain the ack of the abandoned fetch and discard its data.
               if (nv_ack || cnt_reg == CNT_LAST) begin
                  cnt_reg   <= '0;
                  state_reg <= IDLE;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end

            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nvram_upload_reader.sv
// Testbench for nvram_upload_reader. A behavioural arbiter answers nv_req
// after a programmable number of cycles, or never. Expected bytes are queued
// when a read is issued and popped when the returned byte becomes valid.
module tb_nvram_upload_reader;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_upload;
   logic [7:0]  ioctl_index;
   logic [24:0] ioctl_addr;
   logic        ioctl_rd;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic        nv_req;
   logic [9:0]  nv_addr;
   logic [7:0]  nv_data;
   logic        nv_ack;
   logic        nv_hold;
   logic        done;
   logic        timeout_err;

   always #5 clk_sys = ~clk_sys;

   nvram_upload_reader dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .ioctl_upload (ioctl_upload),
      .ioctl_index  (ioctl_index),
      .ioctl_addr   (ioctl_addr),
      .ioctl_rd     (ioctl_rd),
      .ioctl_din    (ioctl_din),
      .ioctl_wait   (ioctl_wait),
      .nv_req       (nv_req),
      .nv_addr      (nv_addr),
      .nv_data      (nv_data),
      .nv_ack       (nv_ack),
      .nv_hold      (nv_hold),
      .done         (done),
      .timeout_err  (timeout_err)
   );

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Arbiter model: acks on the arb_delay-th cycle nv_req is seen high.
   // arb_delay of 0 means it never answers.
   bit         arb_en = 1'b0;
   int         arb_delay = 1;
   bit         arb_fixed_en = 1'b0;
   logic [7:0] arb_fixed = 8'h00;
   logic       arb_ack = 1'b0;
   logic [7:0] arb_data = 8'h00;
   int         hi_cnt = 0;
   logic       man_ack = 1'b0;
   logic [7:0] man_data = 8'h00;

   always @(negedge clk_sys) begin
      arb_ack = 1'b0;
      if (arb_en && nv_req) begin
         hi_cnt++;
         if (arb_delay != 0 && hi_cnt == arb_delay) begin
            arb_ack  = 1'b1;
            arb_data = arb_fixed_en ? arb_fixed : nv_addr[7:0];
         end
      end else begin
         hi_cnt = 0;
      end
   end

   assign nv_ack  = arb_en ? arb_ack : man_ack;
   assign nv_data = arb_en ? arb_data : man_data;

   // Issue one strobe, wait (bounded) for the byte, then compare it against
   // the scoreboard head. Reports the wait-high cycles and whether nv_req
   // was seen at any point.
   task automatic do_read(input logic [24:0] a, input logic [7:0] exp,
                          output int wc, output bit rs);
      logic [7:0] want;
      exp_q.push_back(exp);
      @(negedge clk_sys);
      ioctl_addr = a;
      ioctl_rd   = 1'b1;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      wc = 0;
      rs = 1'b0;
      while (ioctl_wait && wc < 200) begin
         rs = rs | nv_req;
         wc++;
         @(negedge clk_sys);
      end
      rs = rs | nv_req;
      if (wc >= 200)
         check("wait_bound", 32'(wc), 32'd0);
      want = exp_q.pop_front();
      check("din", {24'h0, ioctl_din}, {24'h0, want});
      $display("rd addr=%03h din=%02h exp=%02h wait=%0d", a, ioctl_din, want, wc);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_din"},  {24'h0, ioctl_din}, 32'h0);
      check({tag, "_wait"}, {31'h0, ioctl_wait}, 32'h0);
      check({tag, "_req"},  {31'h0, nv_req}, 32'h0);
      check({tag, "_addr"}, {22'h0, nv_addr}, 32'h0);
      check({tag, "_hold"}, {31'h0, nv_hold}, 32'h0);
      check({tag, "_done"}, {31'h0, done}, 32'h0);
      check({tag, "_terr"}, {31'h0, timeout_err}, 32'h0);
   endtask

   initial begin
      int wc;
      bit rs;
      int done_cnt;
      bit any_req;
      bit any_hold;

      reset        = 1'b1;
      ioctl_upload = 1'b0;
      ioctl_index  = 8'd4;
      ioctl_addr   = '0;
      ioctl_rd     = 1'b0;
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
      @(negedge clk_sys);
      check_reset_state("rst");

      ioctl_upload = 1'b1;
      repeat (2) @(negedge clk_sys);
      check("hold_on", {31'h0, nv_hold}, 32'h1);

      // Single read, ack on the third request cycle.
      arb_en = 1'b1; arb_delay = 3; arb_fixed_en = 1'b1; arb_fixed = 8'h5A;
      do_read(25'h005, 8'h5A, wc, rs);
      check("t1_wait", 32'(wc), 32'd3);
      check("t1_addr", {22'h0, nv_addr}, 32'h005);
      check("t1_wait_low", {31'h0, ioctl_wait}, 32'h0);

      // Full image with a zero-wait arbiter returning addr[7:0].
      arb_delay = 1; arb_fixed_en = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         do_read(25'(i), 8'(i), wc, rs);
         if (i == 0)
            check("seq_wait", 32'(wc), 32'd1);
      end
      check("seq_terr", {31'h0, timeout_err}, 32'h0);
      ioctl_upload = 1'b0;
      done_cnt = 0;
      repeat (5) begin
         @(negedge clk_sys);
         done_cnt += int'(done);
      end
      check("seq_done", 32'(done_cnt), 32'd1);
      ioctl_upload = 1'b1;
      repeat (2) @(negedge clk_sys);

      // Out-of-range address: fill byte, no request, no stall.
      do_read(25'h400, 8'hFF, wc, rs);
      check("oor_wait", 32'(wc), 32'd0);
      check("oor_req", {31'h0, rs}, 32'h0);
      check("oor_addr", {22'h0, nv_addr}, 32'h3FF);

      // Arbiter never answers.
      arb_delay = 0;
      do_read(25'h123, 8'hEE, wc, rs);
      check("tmo_wait", 32'(wc), 32'd63);
      check("tmo_terr", {31'h0, timeout_err}, 32'h1);
      ioctl_upload = 1'b0;
      @(negedge clk_sys);
      check("tmo_sticky", {31'h0, timeout_err}, 32'h1);
      ioctl_upload = 1'b1;
      repeat (2) @(negedge clk_sys);
      check("tmo_clear", {31'h0, timeout_err}, 32'h0);

      // Ack arrives on the 63rd request cycle: the ack wins.
      arb_delay = 63; arb_fixed_en = 1'b1; arb_fixed = 8'h3C;
      do_read(25'h0AA, 8'h3C, wc, rs);
      check("tie_wait", 32'(wc), 32'd63);
      check("tie_terr", {31'h0, timeout_err}, 32'h0);

      // Non-matching index: strobes ignored.
      ioctl_upload = 1'b0;
      repeat (3) @(negedge clk_sys);
      ioctl_index  = 8'd1;
      ioctl_upload = 1'b1;
      any_req = 1'b0; any_hold = 1'b0; done_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_sys);
         ioctl_addr = 25'(i * 7);
         ioctl_rd   = 1'b1;
         any_req |= nv_req; any_hold |= nv_hold; done_cnt += int'(done);
         @(negedge clk_sys);
         ioctl_rd = 1'b0;
         any_req |= nv_req; any_hold |= nv_hold; done_cnt += int'(done);
      end
      ioctl_upload = 1'b0;
      repeat (3) begin
         @(negedge clk_sys);
         any_req |= nv_req; any_hold |= nv_hold; done_cnt += int'(done);
      end
      check("idx_req", {31'h0, any_req}, 32'h0);
      check("idx_hold", {31'h0, any_hold}, 32'h0);
      check("idx_done", 32'(done_cnt), 32'd0);
      check("idx_din", {24'h0, ioctl_din}, 32'h3C);
      ioctl_index  = 8'd4;
      ioctl_upload = 1'b1;
      repeat (2) @(negedge clk_sys);

      // Session drops mid-fetch, then a late ack arrives.
      arb_en = 1'b0;
      @(negedge clk_sys);
      ioctl_addr = 25'h010;
      ioctl_rd   = 1'b1;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      check("ab_req", {31'h0, nv_req}, 32'h1);
      check("ab_wait", {31'h0, ioctl_wait}, 32'h1);
      @(negedge clk_sys);
      ioctl_upload = 1'b0;
      @(negedge clk_sys);
      check("ab_req_drop", {31'h0, nv_req}, 32'h0);
      check("ab_wait_drop", {31'h0, ioctl_wait}, 32'h0);
      check("ab_done", {31'h0, done}, 32'h1);
      @(negedge clk_sys);
      man_data = 8'h77;
      man_ack  = 1'b1;
      @(negedge clk_sys);
      man_ack = 1'b0;
      check("ab_din", {24'h0, ioctl_din}, 32'h3C);
      ioctl_upload = 1'b1;
      arb_en = 1'b1; arb_delay = 1; arb_fixed_en = 1'b0;
      @(negedge clk_sys);
      do_read(25'h020, 8'h20, wc, rs);
      check("ab_idle", 32'(wc), 32'd1);

      // Set timeout_err, then pulse reset mid-fetch.
      arb_delay = 0;
      do_read(25'h030, 8'hEE, wc, rs);
      check("rs_terr", {31'h0, timeout_err}, 32'h1);
      arb_en = 1'b0;
      @(negedge clk_sys);
      ioctl_addr = 25'h040;
      ioctl_rd   = 1'b1;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      check("rs_req", {31'h0, nv_req}, 32'h1);
      check("rs_addr", {22'h0, nv_addr}, 32'h040);
      #2 reset = 1'b1;
      #1 check_reset_state("arst");
      @(negedge clk_sys);
      reset = 1'b0;
      man_data = 8'h77;
      man_ack  = 1'b1;
      @(negedge clk_sys);
      man_ack = 1'b0;
      @(negedge clk_sys);
      check("late_req", {31'h0, nv_req}, 32'h0);
      check("late_wait", {31'h0, ioctl_wait}, 32'h0);
      check("late_din", {24'h0, ioctl_din}, 32'h0);
      check("late_addr", {22'h0, nv_addr}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
